// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner enums and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, REQ_IF, REQ_D, RSP_IF, RSP_D} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker; remembers the last granted owner.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  logic   i_upd,
    input  owner_e i_owner,
    output owner_e o_winner
);
    owner_e r_last;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_last <= OWN_IF;
        else if (i_upd) r_last <= i_owner;
    end
    // on a tie the owner not served last wins
    assign o_winner = (i_if_req && !i_d_req) ? OWN_IF :
                      (i_d_req && !i_if_req) ? OWN_D  :
                      (r_last == OWN_IF)     ? OWN_D  : OWN_IF;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter between fetch and data ports onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to abort an RSP phase after TIMEOUT cycles with an o_err pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [DW-1:0]   o_if_rdata,
    input  logic            i_d_req,
    input  logic            i_d_we,
    input  logic [DW/8-1:0] i_d_be,
    input  logic [AW-1:0]   i_d_addr,
    input  logic [DW-1:0]   i_d_wdata,
    output logic            o_d_gnt,
    output logic            o_d_rvalid,
    output logic [DW-1:0]   o_d_rdata,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [DW/8-1:0] o_mem_be,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata,
    output logic            o_err
);
    state_e r_state, w_next;
    owner_e w_winner, w_gnt_owner;
    logic   w_upd, w_rsp, w_tmo;

    mem_arb_rr u_rr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_if_req (i_if_req),
        .i_d_req  (i_d_req),
        .i_upd    (w_upd),
        .i_owner  (w_gnt_owner),
        .o_winner (w_winner)
    );

    assign w_rsp       = (r_state == RSP_IF) || (r_state == RSP_D);
    assign w_upd       = ((r_state == REQ_IF) || (r_state == REQ_D)) && i_mem_gnt;
    assign w_gnt_owner = (r_state == REQ_D) ? OWN_D : OWN_IF;
    assign o_err       = w_tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_cnt;
    // counter is zero on the first RSP cycle, so the abort lands on RSP cycle TIMEOUT
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cnt <= '0;
        else r_cnt <= w_rsp ? r_cnt + CW'(1) : '0;
    end
    assign w_tmo = w_rsp && !i_mem_rvalid && (r_cnt == CW'(TIMEOUT - 1));
`else
    // RSP never aborts; TIMEOUT only matters when the counter is built
    assign w_tmo = (TIMEOUT < 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_if_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_d_gnt     = 1'b0;
        o_d_rvalid  = 1'b0;
        o_d_rdata   = '0;
        case (r_state)
            IDLE: begin
                if (i_if_req || i_d_req) w_next = (w_winner == OWN_IF) ? REQ_IF : REQ_D;
            end
            REQ_IF: begin
                o_mem_req  = 1'b1;
                o_mem_be   = '1;
                o_mem_addr = i_if_addr;
                o_if_gnt   = i_mem_gnt;
                if (i_mem_gnt) w_next = RSP_IF;
            end
            REQ_D: begin
                o_mem_req   = 1'b1;
                o_mem_we    = i_d_we;
                o_mem_be    = i_d_be;
                o_mem_addr  = i_d_addr;
                o_mem_wdata = i_d_wdata;
                o_d_gnt     = i_mem_gnt;
                if (i_mem_gnt) w_next = RSP_D;
            end
            RSP_IF: begin
                o_if_rvalid = i_mem_rvalid || w_tmo;
                o_if_rdata  = w_tmo ? '0 : i_mem_rdata;
                if (i_mem_rvalid || w_tmo) w_next = IDLE;
            end
            RSP_D: begin
                o_d_rvalid = i_mem_rvalid || w_tmo;
                o_d_rdata  = w_tmo ? '0 : i_mem_rdata;
                if (i_mem_rvalid || w_tmo) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, transaction-level model checked every negedge, plus literal checks.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic          i_clk, i_rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt, o_if_rvalid;
    logic [DW-1:0] o_if_rdata;
    logic          i_d_req, i_d_we;
    logic [3:0]    i_d_be;
    logic [AW-1:0] i_d_addr;
    logic [DW-1:0] i_d_wdata;
    logic          o_d_gnt, o_d_rvalid;
    logic [DW-1:0] o_d_rdata;
    logic          o_mem_req, o_mem_we;
    logic [3:0]    o_mem_be;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_gnt, i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;
    logic          o_err;

    int n_err = 0;
    int n_chk = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: one transaction slot (active, granted, owner) plus last-served owner
    bit m_act, m_done, m_own, m_last;
    int m_cnt;
    logic m_tmo;
`ifdef MEM_ARB_TIMEOUT_EN
    assign m_tmo = m_act && m_done && !i_mem_rvalid && (m_cnt == TO - 1);
`else
    assign m_tmo = 1'b0;
`endif

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_act <= 0; m_done <= 0; m_last <= 0; m_cnt <= 0;
        end else if (!m_act) begin
            if (i_if_req || i_d_req) begin
                m_act <= 1; m_done <= 0;
                m_own <= (i_if_req && i_d_req) ? !m_last : i_d_req;
            end
        end else if (!m_done) begin
            if (i_mem_gnt) begin
                m_done <= 1; m_last <= m_own; m_cnt <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (i_mem_rvalid || m_tmo) m_act <= 0;
        end
    end

    always @(negedge i_clk) begin
        logic e_req, e_rsp;
        e_req = m_act && !m_done;
        e_rsp = m_act && m_done;
        chk("mem_req", o_mem_req, e_req);
        if (e_req) begin
            chk("mem_we", o_mem_we, m_own && i_d_we);
            chk("mem_be", o_mem_be, m_own ? i_d_be : 4'hF);
            chk("mem_addr", o_mem_addr, m_own ? i_d_addr : i_if_addr);
            if (m_own) chk("mem_wdata", o_mem_wdata, i_d_wdata);
        end
        chk("if_gnt", o_if_gnt, e_req && !m_own && i_mem_gnt);
        chk("d_gnt", o_d_gnt, e_req && m_own && i_mem_gnt);
        chk("if_rvalid", o_if_rvalid, e_rsp && !m_own && (i_mem_rvalid || m_tmo));
        chk("d_rvalid", o_d_rvalid, e_rsp && m_own && (i_mem_rvalid || m_tmo));
        chk("if_rdata", o_if_rdata, (e_rsp && !m_own && !m_tmo) ? i_mem_rdata : 32'h0);
        chk("d_rdata", o_d_rdata, (e_rsp && m_own && !m_tmo) ? i_mem_rdata : 32'h0);
        chk("err", o_err, m_tmo);
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1;
        cyc();
        cyc();
        i_rst = 0;
    endtask

    initial begin
        i_rst = 1; i_if_req = 0; i_if_addr = 0; i_d_req = 0; i_d_we = 0; i_d_be = 0;
        i_d_addr = 0; i_d_wdata = 0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        cyc(); cyc();
        i_mem_rvalid = 1; i_mem_rdata = 32'hFFFF_FFFF;
        #2;
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_if_rvalid", o_if_rvalid, 0);
        chk("rst_if_rdata", o_if_rdata, 0);
        chk("rst_err", o_err, 0);
        i_rst = 0; i_mem_rvalid = 0; i_mem_rdata = 0;

        // single fetch: gnt in cycle 2, rvalid in cycle 4
        cyc(); i_if_req = 1; i_if_addr = 32'h100;
        cyc(); i_mem_gnt = 1; #2;
        chk("t1_if_gnt", o_if_gnt, 1);
        chk("t1_addr", o_mem_addr, 32'h100);
        chk("t1_be", o_mem_be, 4'hF);
        chk("t1_we", o_mem_we, 0);
        cyc(); i_if_req = 0; i_mem_gnt = 0; #2;
        chk("t1_wait", o_if_rvalid, 0);
        cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF; #2;
        chk("t1_rvalid", o_if_rvalid, 1);
        chk("t1_rdata", o_if_rdata, 32'hDEADBEEF);
        cyc(); i_mem_rvalid = 0;

        // tie after reset: data first, then with both pending again fetch wins
        do_reset();
        i_if_req = 1; i_if_addr = 32'h300; i_d_req = 1; i_d_we = 0; i_d_be = 4'hF; i_d_addr = 32'h400;
        cyc(); i_mem_gnt = 1; #2;
        chk("t2_d_gnt", o_d_gnt, 1);
        chk("t2_if_gnt0", o_if_gnt, 0);
        chk("t2_addr_d", o_mem_addr, 32'h400);
        cyc(); i_mem_gnt = 0;
        cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hA5A5_0001; #2;
        chk("t2_d_rvalid", o_d_rvalid, 1);
        chk("t2_d_rdata", o_d_rdata, 32'hA5A5_0001);
        chk("t2_if_rdata0", o_if_rdata, 0);
        cyc(); i_mem_rvalid = 0;
        cyc(); i_mem_gnt = 1; #2;
        chk("t2_if_gnt", o_if_gnt, 1);
        chk("t2_d_gnt0", o_d_gnt, 0);
        chk("t2_addr_if", o_mem_addr, 32'h300);
        cyc(); i_mem_gnt = 0; i_if_req = 0;
        cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'h0BAD_F00D; #2;
        chk("t2_if_rvalid", o_if_rvalid, 1);
        cyc(); i_mem_rvalid = 0; i_d_req = 0;
        cyc(); #2;
        chk("t2_dropped", o_mem_req, 0);

        // byte-masked data write
        i_d_req = 1; i_d_we = 1; i_d_be = 4'b0011; i_d_addr = 32'h2000; i_d_wdata = 32'h1234_5678;
        cyc(); i_mem_gnt = 1; #2;
        chk("t3_we", o_mem_we, 1);
        chk("t3_be", o_mem_be, 4'b0011);
        chk("t3_wdata", o_mem_wdata, 32'h1234_5678);
        chk("t3_addr", o_mem_addr, 32'h2000);
        cyc(); i_d_req = 0; i_d_we = 0; i_mem_gnt = 0;
        cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hFFFF_FFFF; #2;
        chk("t3_d_rvalid", o_d_rvalid, 1);
        chk("t3_if_rvalid0", o_if_rvalid, 0);
        chk("t3_if_rdata0", o_if_rdata, 0);
        cyc(); i_mem_rvalid = 0;

        // stalled grant: owner and payload hold, fetch waits
        i_d_req = 1; i_d_be = 4'hF; i_d_addr = 32'h3000;
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin i_if_req = 1; i_if_addr = 32'h500; end
            #2;
            chk("t4_req", o_mem_req, 1);
            chk("t4_addr", o_mem_addr, 32'h3000);
            chk("t4_if_gnt0", o_if_gnt, 0);
            cyc();
        end
        i_mem_gnt = 1; #2;
        chk("t4_d_gnt", o_d_gnt, 1);
        cyc(); i_mem_gnt = 0; i_d_req = 0;
        cyc(); i_mem_rvalid = 1;
        cyc(); i_mem_rvalid = 0;

        // async reset while in RSP_IF
        cyc(); i_mem_gnt = 1;
        cyc(); i_mem_gnt = 0; i_if_req = 0;
        #2; i_mem_rvalid = 1; i_mem_rdata = 32'h77; i_rst = 1; #1;
        chk("t5_if_rvalid0", o_if_rvalid, 0);
        chk("t5_if_rdata0", o_if_rdata, 0);
        chk("t5_mem_req0", o_mem_req, 0);
        chk("t5_err0", o_err, 0);
        cyc(); i_rst = 0; #2;
        chk("t5_late_rvalid", o_if_rvalid, 0);
        cyc(); i_mem_rvalid = 0; #2;
        chk("t5_idle", o_mem_req, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // no rvalid: abort on the 4th RSP cycle
        i_if_req = 1; i_if_addr = 32'h600;
        cyc(); i_mem_gnt = 1;
        cyc(); i_mem_gnt = 0; i_if_req = 0; i_mem_rdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
            #2; chk("t6_no_err", o_err, 0);
            cyc();
        end
        #2;
        chk("t6_err", o_err, 1);
        chk("t6_rvalid", o_if_rvalid, 1);
        chk("t6_rdata0", o_if_rdata, 0);
        cyc(); #2;
        chk("t6_err_pulse", o_err, 0);
        chk("t6_idle_rvalid", o_if_rvalid, 0);
        chk("t6_idle_req", o_mem_req, 0);
`endif

        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
